// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit selector, y = s ? b : a, with vld_out qualifying y.
// Define MUX_2TO1_REG_OUT_EN to add a PIPE_STAGES-deep registered output path.
module mux_2to1 #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             vld_in,
    output logic [WIDTH-1:0] y,
    output logic             vld_out
);

    // Conditional operator yields X only on bits where a and b differ when s is X/Z.
    logic [WIDTH-1:0] sel_c;
    assign sel_c = s ? b : a;

`ifdef MUX_2TO1_REG_OUT_EN

    logic [WIDTH-1:0]       data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld_q;

    // Data stages advance only behind a valid bit; the valid chain always shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            if (vld_in) begin
                data_q[0] <= sel_c;
            end
            vld_q[0] <= vld_in;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign y       = data_q[PIPE_STAGES-1];
    assign vld_out = vld_q[PIPE_STAGES-1];

`else

    assign y       = sel_c;
    assign vld_out = vld_in;

    // Clock, reset and stage count have no role in the combinational build.
    logic unused_c;
    assign unused_c = ^{clk, rst_n, 32'(PIPE_STAGES)};

`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: a WIDTH=1/PIPE_STAGES=1 and a WIDTH=8/PIPE_STAGES=2 instance.
// Expectations adapt to whether MUX_2TO1_REG_OUT_EN is defined.
module tb_mux_2to1;

`ifdef MUX_2TO1_REG_OUT_EN
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT8 = 2;
`else
    localparam int unsigned LAT1 = 0;
    localparam int unsigned LAT8 = 0;
`endif

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] due;
    } exp_t;

    typedef struct packed {
        logic       s;
        logic       a1;
        logic       b1;
        logic [7:0] a8;
        logic [7:0] b8;
        logic       vld;
        logic       e1;
        logic [7:0] e8;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s = 1'b0;
    logic        vld = 1'b0;
    logic        a1 = 1'b0;
    logic        b1 = 1'b0;
    logic [7:0]  a8 = 8'h00;
    logic [7:0]  b8 = 8'h00;
    logic        y1;
    logic        vld1;
    logic [7:0]  y8;
    logic        vld8;
    logic [31:0] cyc = 32'd0;

    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q8[$];
    logic [7:0] last1 = 8'h00;
    logic [7:0] last8 = 8'h00;

    mux_2to1 #(.WIDTH(1), .PIPE_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s),
        .vld_in(vld), .y(y1), .vld_out(vld1)
    );

    mux_2to1 #(.WIDTH(8), .PIPE_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s),
        .vld_in(vld), .y(y8), .vld_out(vld8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        s   = v.s;
        a1  = v.a1;
        b1  = v.b1;
        a8  = v.a8;
        b8  = v.b8;
        vld = v.vld;
        if (v.vld) begin
            q1.push_back('{data: {7'd0, v.e1}, due: cyc + LAT1});
            q8.push_back('{data: v.e8, due: cyc + LAT8});
        end
`ifndef MUX_2TO1_REG_OUT_EN
        #1;
        chk("comb_y1_immediate", {31'd0, y1}, {31'd0, v.e1});
        chk("comb_y8_immediate", {24'd0, y8}, {24'd0, v.e8});
`endif
    endtask

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp_t e;
`ifdef MUX_2TO1_REG_OUT_EN
        if (!rst_n) begin
            last1 = 8'h00;
        end else
`endif
        if (vld1) begin
            if (q1.size() == 0) begin
                chk("dut1_spurious_vld", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1_data", {31'd0, y1}, {24'd0, e.data});
                chk("dut1_latency", cyc, e.due);
                last1 = e.data;
            end
        end else begin
`ifdef MUX_2TO1_REG_OUT_EN
            chk("dut1_bubble_hold", {31'd0, y1}, {24'd0, last1});
`else
            chk("dut1_bubble_comb", {31'd0, y1}, {31'd0, (s ? b1 : a1)});
`endif
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
`ifdef MUX_2TO1_REG_OUT_EN
        if (!rst_n) begin
            last8 = 8'h00;
        end else
`endif
        if (vld8) begin
            if (q8.size() == 0) begin
                chk("dut8_spurious_vld", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("dut8_data", {24'd0, y8}, {24'd0, e.data});
                chk("dut8_latency", cyc, e.due);
                last8 = e.data;
            end
        end else begin
`ifdef MUX_2TO1_REG_OUT_EN
            chk("dut8_bubble_hold", {24'd0, y8}, {24'd0, last8});
`else
            chk("dut8_bubble_comb", {24'd0, y8}, {24'd0, (s ? b8 : a8)});
`endif
        end
    end

    // Fields: s, a1, b1, a8, b8, vld, e1, e8
    vec_t tbl [14] = '{
        '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00},
        '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hA5},
        '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF},
        '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 8'h12},
        '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h3C},
        '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF},
        '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00},
        '{1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 8'h34},
        '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5},
        '{1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h3C},
        '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5},
        '{1'b0, 1'b1, 1'b0, 8'h5A, 8'hC3, 1'b1, 1'b1, 8'h5A},
        '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00},
        '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00}
    };

    vec_t in_flight = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h77, 1'b1, 1'b1, 8'h77};
    vec_t lat_vec   = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF};
    vec_t idle_vec  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF};

    initial begin
        #2;
        chk("reset_y1", {31'd0, y1}, 32'd0);
        chk("reset_vld1", {31'd0, vld1}, 32'd0);
        chk("reset_y8", {24'd0, y8}, 32'd0);
        chk("reset_vld8", {31'd0, vld8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) drive(tbl[i]);
        repeat (3) drive(tbl[13]);

        // Launch one sample, then reset while it is still in flight in the deep instance.
        drive(in_flight);
        @(posedge clk);
        #1;
        vld = 1'b0;
        #2;
        rst_n = 1'b0;
`ifdef MUX_2TO1_REG_OUT_EN
        q1.delete();
        q8.delete();
`endif
        #1;
`ifdef MUX_2TO1_REG_OUT_EN
        chk("async_reset_y1", {31'd0, y1}, 32'd0);
        chk("async_reset_y8", {24'd0, y8}, 32'd0);
`else
        chk("comb_reset_y1", {31'd0, y1}, 32'd1);
        chk("comb_reset_y8", {24'd0, y8}, 32'h77);
`endif
        chk("reset_vld1_mid", {31'd0, vld1}, 32'd0);
        chk("reset_vld8_mid", {31'd0, vld8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(lat_vec);
        repeat (4) drive(idle_vec);

        repeat (6) @(negedge clk);
        chk("drain_q1_empty", q1.size(), 32'd0);
        chk("drain_q8_empty", q8.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
